// File: rtl/ex_div_unit.sv
// Iterative RV32M divide unit for the EX stage: DIV/DIVU/REM/REMU by restoring
// division, one quotient bit per cycle, holding the pipeline through STALL.
module ex_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DIV_VALID,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            STALL,
  output logic [XLEN-1:0] DIV_RESULT,
  output logic            DIV_RESULT_VALID,
  output logic            BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic              sgn_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   quo_nx, rem_nx, fixed;
  logic              unused_func3;

  // FUNC3[2] is implied by DIV_VALID; only the low bits select the operation.
  assign unused_func3 = FUNC3[2];

  assign sgn_op = ~FUNC3[0];
  assign a_neg  = sgn_op & OPERAND_A[XLEN-1];
  assign b_neg  = sgn_op & OPERAND_B[XLEN-1];
  assign a_mag  = a_neg ? (~OPERAND_A + 1'b1) : OPERAND_A;
  assign b_mag  = b_neg ? (~OPERAND_B + 1'b1) : OPERAND_B;

  // One restoring step; rem stays below the divisor so the shifted value fits XLEN+1.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign quo_nx = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

  // Sign fix-up applied on the final iteration so the result is registered into DONE.
  always_comb begin
    fixed = '0;
    if (is_rem_q) fixed = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    else          fixed = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (DIV_VALID && !FLUSH) begin
          is_rem_d  = FUNC3[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          count_d   = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          if (OPERAND_B == '0) begin
            res_d   = FUNC3[1] ? OPERAND_A : '1;
            state_d = S_DONE;
          end else if (sgn_op && OPERAND_A == MIN_NEG && OPERAND_B == '1) begin
            res_d   = FUNC3[1] ? '0 : MIN_NEG;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (FLUSH || !DIV_VALID) begin
          state_d = S_IDLE;
        end else begin
          quo_d   = quo_nx;
          rem_d   = rem_nx;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            res_d   = fixed;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign STALL            = DIV_VALID & ~FLUSH & (state_q != S_DONE);
  assign DIV_RESULT_VALID = (state_q == S_DONE) & ~FLUSH;
  assign BUSY             = (state_q == S_CALC);
  assign DIV_RESULT       = res_q;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide unit in the EX stage. It consumes the operand and control fields that the ID/EX pipeline register presents: EX_READ_DATA1, EX_READ_DATA2 and EX_FUNC3.
- Executes DIV, DIVU, REM and REMU as a multi-cycle operation.
- Holds the pipeline through a STALL output until the result is ready, then presents it for one cycle so the EX/MEM register captures it.
- Sits beside the single-cycle ALU; the EX result mux selects DIV_RESULT when DIV_RESULT_VALID is high.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- DIV_VALID  input  1  high while a divide-class instruction occupies EX. Held stable by the stall.
- FUNC3  input  3  from EX_FUNC3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  input  XLEN  dividend, from forwarded EX_READ_DATA1.
- OPERAND_B  input  XLEN  divisor, from forwarded EX_READ_DATA2.
- FLUSH  input  1  branch/jump flush of the EX stage; aborts any operation in flight.
- STALL  output  1  freezes PC, IF/ID and ID/EX while the divide is incomplete.
- DIV_RESULT  output  XLEN  quotient or remainder per FUNC3.
- DIV_RESULT_VALID  output  1  one-cycle pulse; result is valid this cycle.
- BUSY  output  1  high in CALC state (debug/perf counter).

Behaviour:
- States: IDLE, CALC, DONE. Encoding is free. All registers are synchronous.
- Reset (RST=1 at a rising edge), applied to any state including mid-CALC:
  - state=IDLE, count=0, quotient/remainder/divisor regs=0.
  - DIV_RESULT=0, DIV_RESULT_VALID=0, BUSY=0.
  - STALL is combinational and evaluates to 0 after reset unless DIV_VALID=1.
- STALL = DIV_VALID & ~FLUSH & (state != DONE). STALL is therefore high in the acceptance cycle and throughout CALC, and low in DONE.
- IDLE, when DIV_VALID=1 and FLUSH=0:
  - Latch FUNC3 and operand signs.
  - Convert operands to magnitudes for signed ops (DIV, REM).
  - Special cases go directly to DONE next cycle with the result preloaded:
    - Divide by zero, OPERAND_B=0: quotient = all ones (0xFFFFFFFF); remainder = OPERAND_A.
    - Signed overflow, DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Otherwise: CALC next cycle with count=0 and partial remainder=0.
- CALC: restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Subtract the divisor magnitude from rem in an XLEN+1-bit subtractor.
  - If the result is non-negative, keep it and set quo[0]=1.
  - count increments each cycle; after XLEN iterations (count==XLEN-1 at the edge) go to DONE.
- DONE:
  - Apply signs. Quotient is negated if sign(A)^sign(B) for DIV. Remainder takes sign(A) for REM.
  - Output DIV_RESULT = quotient for FUNC3[1]=0, remainder for FUNC3[1]=1.
  - DIV_RESULT_VALID=1 for exactly this cycle, then go to IDLE.
  - Sign fix-up is combinational from the final registers into DIV_RESULT, or registered into DONE; either way DIV_RESULT is valid in the DONE cycle.
- Latency, counted from the first cycle DIV_VALID is high to the DIV_RESULT_VALID cycle:
  - Normal: XLEN+2 cycles (34 at XLEN=32): 1 IDLE accept + 32 CALC + 1 DONE.
  - Special case: 2 cycles.
- The pipeline advances on the DONE edge. If the next instruction in EX is also a divide, the IDLE acceptance occurs in the cycle after DONE, with no result carry-over.
- FLUSH=1 in any state: next state IDLE, DIV_RESULT_VALID=0, STALL=0 that cycle, no result. FLUSH takes priority over DONE.
- DIV_VALID dropping in CALC: protocol violation; the unit aborts to IDLE (same as FLUSH).
- DIV_RESULT holds its last value outside DONE. Consumers must qualify it with DIV_RESULT_VALID.
- Operands and FUNC3 are sampled only in IDLE; changes during CALC are ignored.

Test Plan:
- DIVU 100/7: A=100, B=7, FUNC3=101 → STALL high 33 cycles, then DIV_RESULT=14 with VALID one cycle, STALL low the same cycle. REMU on the same operands gives 2.
- Signed: DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1. Each takes 34-cycle latency.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Each after 2 cycles with STALL high for 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Each takes 2-cycle latency.
- FLUSH asserted at CALC count=10 → same cycle STALL=0, next cycle IDLE. No VALID pulse. A following DIVU 9/3 returns 3 with full latency.
- RST asserted mid-CALC → all outputs 0 next cycle. Back-to-back DIVU 0xFFFFFFFF/1 then DIVU 6/3 → results 0xFFFFFFFF then 2, with VALID pulses 34 cycles apart.
